// File: rtl/hamming74_encoder_tx_pkg.sv
// Shared types and helpers for the decoder_proj link.
// Holds the Hamming(7,4) encoder, the injection mask and the TX FSM states.
package decoder_proj_pkg;

    localparam int CW_W  = 7;
    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        SEND_LO,
        SEND_HI
    } tx_state_e;

    typedef struct packed {
        logic [2:0] inj_pos;
        logic [7:0] data;
    } tx_entry_t;

    // cw[6:0] = {d3,d2,d1,p4,d0,p2,p1}
    function automatic logic [CW_W-1:0] hamming74_enc(
        input logic [NIB_W-1:0] d
    );
        logic p1, p2, p4;
        p1 = d[0] ^ d[1] ^ d[3];
        p2 = d[0] ^ d[2] ^ d[3];
        p4 = d[1] ^ d[2] ^ d[3];
        return {d[3], d[2], d[1], p4, d[0], p2, p1};
    endfunction

    // 0 -> no flip, 1..7 -> flip bit (pos-1)
    function automatic logic [CW_W-1:0] inj_mask(
        input logic [2:0] pos
    );
        logic [CW_W-1:0] m;
        m = '0;
        if (pos != 3'd0) begin
            m[pos - 3'd1] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/hamming74_encoder_tx_if.sv
// Byte-in / codeword-out handshake bundle of the TX encoder.
// slave: encoder side; master: byte source and codeword sink.
interface hamming74_encoder_tx_if;
    import decoder_proj_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [7:0]      in_data;
    logic [2:0]      in_inj_pos;
    logic            cw_valid;
    logic            cw_ready;
    logic [CW_W-1:0] cw_data;
    logic            cw_hi;

    modport slave (
        input  in_valid, in_data, in_inj_pos, cw_ready,
        output in_ready, cw_valid, cw_data, cw_hi
    );

    modport master (
        output in_valid, in_data, in_inj_pos, cw_ready,
        input  in_ready, cw_valid, cw_data, cw_hi
    );

endinterface

// File: rtl/hamming74_tx_fifo.sv
// Byte FIFO of {inj_pos,data} entries; pointers carry one extra wrap bit.
// Ports: clock, rst_n, wr_en/wr_data, rd_en/rd_data, level, full, empty.
module hamming74_tx_fifo
    import decoder_proj_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  tx_entry_t                wr_data,
    input  logic                     rd_en,
    output tx_entry_t                rd_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    tx_entry_t       mem [DEPTH];
    logic [AW:0]     wr_ptr;
    logic [AW:0]     rd_ptr;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + LW'(1);
            if (rd_en) rd_ptr <= rd_ptr + LW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    assign rd_data = mem[rd_ptr[AW-1:0]];
    assign level   = wr_ptr - rd_ptr;
    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);

endmodule

// File: rtl/hamming74_encoder_tx.sv
// TX end of the decoder_proj link: buffers bytes, emits low then high
// Hamming(7,4) codewords. Ports: clock, rst_n, bus (slave), fifo_level, cw_count.
module hamming74_encoder_tx
    import decoder_proj_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                   clock,
    input  logic                   rst_n,
    hamming74_encoder_tx_if.slave  bus,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic [CNT_W-1:0]       cw_count
);

    tx_entry_t       wr_ent;
    tx_entry_t       rd_ent;
    logic            full;
    logic            empty;
    logic            pop;
    logic            rdy_q;

    tx_state_e       state_q, state_d;
    logic [CW_W-1:0] cw_q, cw_d;
    logic            hi_q, hi_d;
    logic            vld_q, vld_d;
    logic [3:0]      nib_q, nib_d;

    assign wr_ent = '{inj_pos: bus.in_inj_pos, data: bus.in_data};

    hamming74_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock   (clock),
        .rst_n   (rst_n),
        .wr_en   (bus.in_valid & bus.in_ready),
        .wr_data (wr_ent),
        .rd_en   (pop),
        .rd_data (rd_ent),
        .level   (fifo_level),
        .full    (full),
        .empty   (empty)
    );

    // Held low through reset, rises on the first edge after release.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) rdy_q <= 1'b0;
        else        rdy_q <= 1'b1;
    end

    assign bus.in_ready = rdy_q & ~full;

    always_comb begin
        state_d = state_q;
        cw_d    = cw_q;
        hi_d    = hi_q;
        vld_d   = vld_q;
        nib_d   = nib_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    cw_d    = hamming74_enc(rd_ent.data[3:0])
                            ^ inj_mask(rd_ent.inj_pos);
                    nib_d   = rd_ent.data[7:4];
                    hi_d    = 1'b0;
                    vld_d   = 1'b1;
                    state_d = SEND_LO;
                end
            end
            SEND_LO: begin
                if (bus.cw_ready) begin
                    cw_d    = hamming74_enc(nib_q);
                    hi_d    = 1'b1;
                    state_d = SEND_HI;
                end
            end
            SEND_HI: begin
                if (bus.cw_ready) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        cw_d    = hamming74_enc(rd_ent.data[3:0])
                                ^ inj_mask(rd_ent.inj_pos);
                        nib_d   = rd_ent.data[7:4];
                        hi_d    = 1'b0;
                        state_d = SEND_LO;
                    end else begin
                        vld_d   = 1'b0;
                        hi_d    = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cw_q    <= '0;
            hi_q    <= 1'b0;
            vld_q   <= 1'b0;
            nib_q   <= '0;
        end else begin
            state_q <= state_d;
            cw_q    <= cw_d;
            hi_q    <= hi_d;
            vld_q   <= vld_d;
            nib_q   <= nib_d;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            cw_count <= '0;
        end else if (vld_q && bus.cw_ready) begin
            cw_count <= cw_count + CNT_W'(1);
        end
    end

    assign bus.cw_valid = vld_q;
    assign bus.cw_data  = cw_q;
    assign bus.cw_hi    = hi_q;

endmodule

// File: tb/tb_hamming74_encoder_tx.sv
// Testbench for hamming74_encoder_tx: vector table, directed corners,
// and randomized traffic against a position-based Hamming reference.
module tb_hamming74_encoder_tx;

    logic        clock;
    logic        rst_n;
    logic [2:0]  fifo_level;
    logic [15:0] cw_count;

    hamming74_encoder_tx_if bus();

    hamming74_encoder_tx #(.DEPTH(4), .CNT_W(16)) dut (
        .clock      (clock),
        .rst_n      (rst_n),
        .bus        (bus),
        .fifo_level (fifo_level),
        .cw_count   (cw_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    function automatic void check(string nm, logic [31:0] act,
                                  logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    // Reference: classic positional Hamming code, positions 1..7,
    // position p stored at cw bit p-1, parity at positions 1,2,4.
    function automatic logic [6:0] ref_enc(logic [3:0] d);
        logic [6:0] c;
        int dpos[4];
        dpos = '{3, 5, 6, 7};
        c = '0;
        for (int i = 0; i < 4; i++) c[dpos[i]-1] = d[i];
        for (int k = 0; k < 3; k++) begin
            logic par;
            par = 1'b0;
            for (int q = 1; q <= 7; q++)
                if ((q & (1 << k)) != 0) par ^= c[q-1];
            c[(1 << k) - 1] = par;
        end
        return c;
    endfunction

    function automatic logic [3:0] ref_dec(logic [6:0] cw);
        int s;
        logic [6:0] c;
        c = cw;
        s = 0;
        for (int p = 1; p <= 7; p++) if (c[p-1]) s ^= p;
        if (s != 0) c[s-1] = ~c[s-1];
        return {c[6], c[5], c[4], c[2]};
    endfunction

    logic [7:0] exp_q[$];
    logic [7:0] byte_q[$];
    logic       mon_en = 1'b0;
    int         wr_seen = 0;
    logic       have_prev = 1'b0;
    logic       prev_v, prev_r, prev_hi;
    logic [6:0] prev_d;
    logic [3:0] lo_dec;

    task automatic model_push(logic [7:0] d, logic [2:0] inj);
        logic [6:0] lo;
        lo = ref_enc(d[3:0]);
        if (inj != 0) lo = lo ^ 7'(1 << (inj - 1));
        exp_q.push_back({1'b0, lo});
        exp_q.push_back({1'b1, ref_enc(d[7:4])});
        byte_q.push_back(d);
    endtask

    always @(negedge clock) begin
        if (!mon_en) begin
            have_prev = 1'b0;
        end else begin
            if (bus.in_valid && bus.in_ready) begin
                model_push(bus.in_data, bus.in_inj_pos);
                wr_seen++;
            end
            if (have_prev && prev_v && !prev_r) begin
                check("hold_valid", 32'(bus.cw_valid), 32'd1);
                check("hold_data", 32'(bus.cw_data), 32'(prev_d));
                check("hold_hi", 32'(bus.cw_hi), 32'(prev_hi));
            end
            if (bus.cw_valid && bus.cw_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_cw: got %0h expected none",
                             bus.cw_data);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    check("cw_hi", 32'(bus.cw_hi), 32'(e[7]));
                    check("cw_data", 32'(bus.cw_data), 32'(e[6:0]));
                    if (!bus.cw_hi) begin
                        lo_dec = ref_dec(bus.cw_data);
                    end else if (byte_q.size() != 0) begin
                        check("decoded_byte",
                              32'({ref_dec(bus.cw_data), lo_dec}),
                              32'(byte_q.pop_front()));
                    end
                end
            end
            have_prev = 1'b1;
            prev_v    = bus.cw_valid;
            prev_r    = bus.cw_ready;
            prev_d    = bus.cw_data;
            prev_hi   = bus.cw_hi;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        logic [7:0] data;
        logic [2:0] inj;
        logic [6:0] lo;
        logic [6:0] hi;
    } vec_t;

    vec_t vecs[6];
    logic [7:0] fill[4];

    initial begin
        logic [15:0] cnt0;
        int cyc;

        vecs[0] = '{8'h00, 3'd0, 7'h00, 7'h00};
        vecs[1] = '{8'hB1, 3'd0, 7'h07, 7'h55};
        vecs[2] = '{8'hFF, 3'd0, 7'h7F, 7'h7F};
        vecs[3] = '{8'h00, 3'd3, 7'h04, 7'h00};
        vecs[4] = '{8'hFF, 3'd7, 7'h3F, 7'h7F};
        vecs[5] = '{8'h3C, 3'd1, 7'h60, 7'h1E};
        fill    = '{8'h12, 8'h34, 8'hC7, 8'h9E};

        rst_n          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.in_inj_pos = '0;
        bus.cw_ready   = 1'b0;
        tick();
        tick();
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_cw_valid", 32'(bus.cw_valid), 32'd0);
        check("rst_cw_data", 32'(bus.cw_data), 32'd0);
        check("rst_cw_hi", 32'(bus.cw_hi), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_count", 32'(cw_count), 32'd0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        check("rdy_before_edge", 32'(bus.in_ready), 32'd0);
        tick();
        check("rdy_after_edge", 32'(bus.in_ready), 32'd1);

        // table-driven single bytes, sink always ready
        bus.cw_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.in_valid   = 1'b1;
            bus.in_data    = vecs[i].data;
            bus.in_inj_pos = vecs[i].inj;
            tick();
            bus.in_valid = 1'b0;
            check("lat_not_yet", 32'(bus.cw_valid), 32'd0);
            tick();
            check("vec_lo_valid", 32'(bus.cw_valid), 32'd1);
            check("vec_lo_hi", 32'(bus.cw_hi), 32'd0);
            check("vec_lo", 32'(bus.cw_data), 32'(vecs[i].lo));
            tick();
            check("vec_hi_hi", 32'(bus.cw_hi), 32'd1);
            check("vec_hi", 32'(bus.cw_data), 32'(vecs[i].hi));
            tick();
            check("vec_idle", 32'(bus.cw_valid), 32'd0);
            if (i == 0) check("count_two", 32'(cw_count), 32'd2);
        end

        // fill FIFO behind a stalled codeword, then drain back-to-back
        bus.cw_ready   = 1'b0;
        bus.in_inj_pos = 3'd0;
        bus.in_valid   = 1'b1;
        bus.in_data    = 8'h5A;
        tick();
        bus.in_valid = 1'b0;
        tick();
        check("stall_valid", 32'(bus.cw_valid), 32'd1);
        check("stall_level", 32'(fifo_level), 32'd0);
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = fill[i];
            tick();
        end
        bus.in_valid = 1'b0;
        check("full_level", 32'(fifo_level), 32'd4);
        check("full_ready", 32'(bus.in_ready), 32'd0);
        cnt0 = cw_count;
        bus.cw_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("b2b_valid", 32'(bus.cw_valid), 32'd1);
            tick();
        end
        check("drain_idle", 32'(bus.cw_valid), 32'd0);
        check("drain_level", 32'(fifo_level), 32'd0);
        check("drain_count", 32'(cw_count), 32'(16'(cnt0 + 16'd10)));

        // random traffic with random backpressure and injection
        begin
            int target;
            target = wr_seen + 200;
            cyc = 0;
            while (!(wr_seen >= target && exp_q.size() == 0
                     && !bus.cw_valid) && cyc < 6000) begin
                bus.cw_ready = 1'($urandom % 2);
                if (wr_seen < target) begin
                    bus.in_valid   = 1'($urandom % 2);
                    bus.in_data    = 8'($urandom);
                    bus.in_inj_pos = 3'($urandom % 8);
                end else begin
                    bus.in_valid = 1'b0;
                end
                tick();
                cyc++;
            end
            bus.in_valid = 1'b0;
            check("rand_done", 32'(cyc < 6000), 32'd1);
        end

        // reset during SEND_HI with two bytes queued
        bus.cw_ready   = 1'b0;
        bus.in_inj_pos = 3'd0;
        bus.in_valid   = 1'b1;
        bus.in_data    = 8'hA5;
        tick();
        bus.in_data    = 8'h3C;
        bus.in_inj_pos = 3'd2;
        tick();
        bus.in_data    = 8'h7E;
        bus.in_inj_pos = 3'd0;
        tick();
        bus.in_valid = 1'b0;
        check("pre_lvl", 32'(fifo_level), 32'd2);
        bus.cw_ready = 1'b1;
        tick();
        bus.cw_ready = 1'b0;
        check("pre_hi", 32'(bus.cw_hi), 32'd1);
        check("pre_valid", 32'(bus.cw_valid), 32'd1);
        check("pre_lvl2", 32'(fifo_level), 32'd2);
        mon_en = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(bus.cw_valid), 32'd0);
        check("arst_data", 32'(bus.cw_data), 32'd0);
        check("arst_hi", 32'(bus.cw_hi), 32'd0);
        check("arst_level", 32'(fifo_level), 32'd0);
        check("arst_count", 32'(cw_count), 32'd0);
        check("arst_ready", 32'(bus.in_ready), 32'd0);
        exp_q.delete();
        byte_q.delete();
        tick();
        tick();
        rst_n  = 1'b1;
        tick();
        mon_en       = 1'b1;
        bus.cw_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("no_stale", 32'(bus.cw_valid), 32'd0);
            tick();
        end
        check("post_count", 32'(cw_count), 32'd0);
        check("post_level", 32'(fifo_level), 32'd0);
        check("model_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
